// File: rtl/skylark_pkg.sv
// Shared Skylark-V definitions: word width, NOP encoding, the opcodes the
// control unit decodes, and the fetch FSM state type.
package skylark_pkg;

  localparam int XLEN = 32;

  // ADDI x0,x0,0 -- the canonical bubble
  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_RTYPE  = 7'b0110011;
  localparam logic [6:0] OP_ITYPE  = 7'b0010011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;

  typedef enum logic [1:0] {BOOT, FETCH, WAIT} fetch_state_t;

endpackage

// File: rtl/if_id_reg.sv
// IF/ID pipeline register. Priority: flush/redirect bubble, then stall hold,
// then load of a completed fetch, otherwise bubble.
// Optional macro FETCH_MISALIGN_TRAP_EN adds the misalign tag path.
module if_id_reg
  import skylark_pkg::*;
(
  input  logic            clk,
  input  logic            rst_n,
  input  logic            StallD,
  input  logic            FlushD,
  input  logic            PCSrcE,
  input  logic            loadEn,
  input  logic [XLEN-1:0] instrF,
  input  logic [XLEN-1:0] pcF,
  input  logic [XLEN-1:0] pcPlus4F,
`ifdef FETCH_MISALIGN_TRAP_EN
  input  logic            misF,
  output logic            MisalignD,
`endif
  output logic [XLEN-1:0] InstrD,
  output logic [XLEN-1:0] PCD,
  output logic [XLEN-1:0] PCPlus4D,
  output logic            ValidD
);

  // Register update: bubble on flush/redirect or when nothing valid arrives
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      InstrD    <= NOP_INSTR;
      PCD       <= '0;
      PCPlus4D  <= '0;
      ValidD    <= 1'b0;
`ifdef FETCH_MISALIGN_TRAP_EN
      MisalignD <= 1'b0;
`endif
    end else if (!StallD || FlushD || PCSrcE) begin
      if (loadEn && !FlushD && !PCSrcE) begin
`ifdef FETCH_MISALIGN_TRAP_EN
        // a misaligned-redirect landing is tagged and its word suppressed
        InstrD    <= misF ? NOP_INSTR : instrF;
        MisalignD <= misF;
`else
        InstrD    <= instrF;
`endif
        PCD       <= pcF;
        PCPlus4D  <= pcPlus4F;
        ValidD    <= 1'b1;
      end else begin
        InstrD    <= NOP_INSTR;
        PCD       <= '0;
        PCPlus4D  <= '0;
        ValidD    <= 1'b0;
`ifdef FETCH_MISALIGN_TRAP_EN
        MisalignD <= 1'b0;
`endif
      end
    end
  end

endmodule

// File: rtl/fetch_stage.sv
// Skylark-V instruction fetch: PCF, imem req/ready FSM, redirect handling
// (immediate or deferred while a fetch is outstanding), plus the IF/ID register.
// Optional macro FETCH_MISALIGN_TRAP_EN: adds MisalignD and traps misaligned
// redirect targets.
module fetch_stage #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          XLEN     = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            StallF,
  input  logic            StallD,
  input  logic            FlushD,
  input  logic            PCSrcE,
  input  logic [XLEN-1:0] PCTargetE,
  output logic            imem_req,
  output logic [XLEN-1:0] imem_addr,
  input  logic            imem_ready,
  input  logic [XLEN-1:0] imem_rdata,
  output logic [XLEN-1:0] InstrD,
  output logic [XLEN-1:0] PCD,
  output logic [XLEN-1:0] PCPlus4D,
  output logic            ValidD,
  output logic [6:0]      OpD,
  output logic [2:0]      Funct3D,
  output logic            Funct7b5D,
`ifdef FETCH_MISALIGN_TRAP_EN
  output logic            MisalignD,
`endif
  output logic            FetchBusyF
);
  import skylark_pkg::*;

  fetch_state_t    state;
  logic [XLEN-1:0] PCF, pcPlus4F, pendTarget, tgtAligned;
  logic            pendValid, complete, discard, loadEn;

  // the low two target bits never reach PCF; word fetches only
  assign tgtAligned = PCTargetE & ~XLEN'(3);
  assign pcPlus4F   = PCF + XLEN'(4);
  assign imem_req   = (state != BOOT);
  assign imem_addr  = PCF;
  assign FetchBusyF = (state == WAIT) || ((state == FETCH) && !imem_ready);
  assign complete   = imem_req && imem_ready;
  // a word returning under a live or deferred redirect is from the wrong path
  assign discard    = PCSrcE || pendValid;
  assign loadEn     = complete && !discard;

  // PC and fetch FSM; addr is frozen while a request is unanswered
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= BOOT;
      PCF        <= RESET_PC;
      pendValid  <= 1'b0;
      pendTarget <= '0;
    end else begin
      case (state)
        BOOT: begin
          state <= FETCH;
          if (PCSrcE) PCF <= tgtAligned;
        end
        FETCH: begin
          if (imem_ready) begin
            if (PCSrcE)       PCF <= tgtAligned;
            else if (!StallF) PCF <= pcPlus4F;
          end else begin
            state <= WAIT;
            if (PCSrcE) begin
              pendValid  <= 1'b1;
              pendTarget <= tgtAligned;
            end
          end
        end
        WAIT: begin
          if (imem_ready) begin
            state     <= FETCH;
            pendValid <= 1'b0;
            if (PCSrcE)         PCF <= tgtAligned;
            else if (pendValid) PCF <= pendTarget;
            else if (!StallF)   PCF <= pcPlus4F;
          end else if (PCSrcE) begin
            pendValid  <= 1'b1;
            pendTarget <= tgtAligned;
          end
        end
        default: state <= BOOT;
      endcase
    end
  end

`ifdef FETCH_MISALIGN_TRAP_EN
  logic misArm;

  // arm the trap on a misaligned redirect; disarm once the landing word enters Decode
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                                misArm <= 1'b0;
    else if (PCSrcE)                           misArm <= (PCTargetE[1:0] != 2'b00);
    else if (loadEn && !StallD && !FlushD)     misArm <= 1'b0;
  end
`endif

  if_id_reg uIfId (
    .clk      (clk),
    .rst_n    (rst_n),
    .StallD   (StallD),
    .FlushD   (FlushD),
    .PCSrcE   (PCSrcE),
    .loadEn   (loadEn),
    .instrF   (imem_rdata),
    .pcF      (PCF),
    .pcPlus4F (pcPlus4F),
`ifdef FETCH_MISALIGN_TRAP_EN
    .misF     (misArm),
    .MisalignD(MisalignD),
`endif
    .InstrD   (InstrD),
    .PCD      (PCD),
    .PCPlus4D (PCPlus4D),
    .ValidD   (ValidD)
  );

  assign OpD       = InstrD[6:0];
  assign Funct3D   = InstrD[14:12];
  assign Funct7b5D = InstrD[30];

endmodule

// File: tb/tb_fetch_stage.sv
// Scoreboard bench for fetch_stage: the model is a program-order stream of
// (pc, word) pairs restarted on every reset/redirect; a monitor pops one
// entry per new valid Decode entry and checks the imem handshake.
module tb_fetch_stage;
  import skylark_pkg::*;

  localparam logic [31:0] RPC = 32'h0000_0000;

  logic        clk, rst_n, StallF, StallD, FlushD, PCSrcE, imem_ready;
  logic [31:0] PCTargetE, imem_addr, imem_rdata, InstrD, PCD, PCPlus4D;
  logic        imem_req, ValidD, Funct7b5D, FetchBusyF;
  logic [6:0]  OpD;
  logic [2:0]  Funct3D;
`ifdef FETCH_MISALIGN_TRAP_EN
  logic        MisalignD;
`endif

  int errors = 0;
  int checks = 0;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
    logic        mis;
  } exp_t;
  exp_t sbq[$];

  fetch_stage #(.RESET_PC(RPC), .XLEN(32)) dut (
    .clk(clk), .rst_n(rst_n), .StallF(StallF), .StallD(StallD), .FlushD(FlushD),
    .PCSrcE(PCSrcE), .PCTargetE(PCTargetE), .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_ready(imem_ready), .imem_rdata(imem_rdata), .InstrD(InstrD), .PCD(PCD),
    .PCPlus4D(PCPlus4D), .ValidD(ValidD), .OpD(OpD), .Funct3D(Funct3D),
    .Funct7b5D(Funct7b5D),
`ifdef FETCH_MISALIGN_TRAP_EN
    .MisalignD(MisalignD),
`endif
    .FetchBusyF(FetchBusyF)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // instruction memory contents
  function automatic logic [31:0] memWord(input logic [31:0] a);
    if (a == 32'h0000_0000) return 32'h0070_0093;
    if (a == 32'h0000_000C) return 32'h0020_81B3;
    return (a * 32'h9E37_79B1) ^ 32'h5A5A_0F33;
  endfunction

  assign imem_rdata = memWord(imem_addr);

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, expv);
    end
  endtask

  // restart the expected program-order stream at 'start'
  task automatic sbLoad(input logic [31:0] start, input logic mis);
    logic [31:0] p;
    exp_t e;
    p = start;
    sbq.delete();
    for (int i = 0; i < 256; i++) begin
      e.pc    = p;
      e.mis   = mis && (i == 0);
      e.instr = e.mis ? NOP_INSTR : memWord(p);
      sbq.push_back(e);
      p = p + 32'd4;
    end
  endtask

  task automatic nxt();
    @(negedge clk);
    #1;
  endtask

  task automatic redirect(input logic [31:0] t);
    logic mis;
`ifdef FETCH_MISALIGN_TRAP_EN
    mis = (t[1:0] != 2'b00);
`else
    mis = 1'b0;
`endif
    PCSrcE    = 1'b1;
    FlushD    = 1'b1;
    PCTargetE = t;
    sbLoad(t & 32'hFFFF_FFFC, mis);
  endtask

  task automatic doReset();
    rst_n = 1'b0;
    StallF = 1'b0; StallD = 1'b0; FlushD = 1'b0; PCSrcE = 1'b0;
    imem_ready = 1'b1;
    nxt();
    nxt();
    rst_n = 1'b1;
    sbLoad(RPC, 1'b0);
  endtask

  task automatic waitAddr(input logic [31:0] a);
    int n;
    n = 0;
    while (imem_addr !== a && n < 40) begin
      nxt();
      n++;
    end
    chk("reach_addr", imem_addr, a);
  endtask

  // monitor: handshake stability, busy flag, and Decode stream vs scoreboard
  initial begin
    logic        pReq, lastV;
    logic [31:0] pAddr;
    exp_t        last, e;
    pReq = 1'b0; lastV = 1'b0; pAddr = '0; last = '0;
    forever begin
      @(negedge clk);
      if (rst_n !== 1'b1) begin
        pReq = 1'b0;
        lastV = 1'b0;
        continue;
      end
      if (pReq && imem_req && !imem_ready) chk("hs_addr_stable", imem_addr, pAddr);
      if (imem_req && !imem_ready) chk("busy_waiting", 32'(FetchBusyF), 32'd1);
      if (!imem_req) chk("busy_idle", 32'(FetchBusyF), 32'd0);
      if (StallD && !PCSrcE && !FlushD) begin
        chk("hold_valid", 32'(ValidD), 32'(lastV));
        if (lastV) begin
          chk("hold_pc", PCD, last.pc);
          chk("hold_instr", InstrD, last.instr);
        end
      end else if (ValidD) begin
        if (sbq.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL sb_empty: got valid pc %h expected no entry", PCD);
        end else begin
          e = sbq.pop_front();
          chk("pcd", PCD, e.pc);
          chk("instr", InstrD, e.instr);
          chk("pcplus4", PCPlus4D, e.pc + 32'd4);
          chk("op", 32'(OpD), 32'(e.instr[6:0]));
          chk("funct3", 32'(Funct3D), 32'(e.instr[14:12]));
          chk("funct7b5", 32'(Funct7b5D), 32'(e.instr[30]));
`ifdef FETCH_MISALIGN_TRAP_EN
          chk("misalign", 32'(MisalignD), 32'(e.mis));
`endif
          last = e;
        end
      end
      lastV = ValidD;
      pReq  = imem_req;
      pAddr = imem_addr;
    end
  end

  // stimulus
  initial begin
    logic [31:0] t;
    int since;
    rst_n = 1'b0; StallF = 1'b0; StallD = 1'b0; FlushD = 1'b0; PCSrcE = 1'b0;
    PCTargetE = '0; imem_ready = 1'b1;

    // reset state and first fetches
    nxt();
    chk("rst_req", 32'(imem_req), 32'd0);
    chk("rst_valid", 32'(ValidD), 32'd0);
    chk("rst_instr", InstrD, NOP_INSTR);
    chk("rst_pcd", PCD, 32'd0);
    chk("rst_pcp4", PCPlus4D, 32'd0);
    chk("rst_addr", imem_addr, RPC);
    nxt();
    rst_n = 1'b1;
    sbLoad(RPC, 1'b0);
    chk("c1_req", 32'(imem_req), 32'd0);
    nxt();
    chk("c2_req", 32'(imem_req), 32'd1);
    chk("c2_addr", imem_addr, 32'd0);
    nxt();
    chk("c3_instr", InstrD, 32'h0070_0093);
    chk("c3_op", 32'(OpD), 32'h13);
    chk("c3_f3", 32'(Funct3D), 32'd0);
    chk("c3_valid", 32'(ValidD), 32'd1);
    chk("c3_nextpc", imem_addr, 32'd4);
    nxt(); nxt(); nxt();
    chk("pc12_op", 32'(OpD), 32'h33);
    chk("pc12_f7b5", 32'(Funct7b5D), 32'd0);
    chk("pc12_pcd", PCD, 32'd12);
    chk("pc12_pcp4", PCPlus4D, 32'd16);

    // ready low for three cycles at addr 8
    doReset();
    waitAddr(32'd8);
    imem_ready = 1'b0;
    repeat (3) begin
      nxt();
      chk("wait_addr", imem_addr, 32'd8);
      chk("wait_busy", 32'(FetchBusyF), 32'd1);
      chk("wait_bubble", 32'(ValidD), 32'd0);
    end
    imem_ready = 1'b1;
    nxt();
    chk("wait_done_pcd", PCD, 32'd8);
    chk("wait_done_valid", 32'(ValidD), 32'd1);

    // redirect while waiting at addr 8
    doReset();
    waitAddr(32'd8);
    imem_ready = 1'b0;
    nxt();
    redirect(32'h100);
    nxt();
    PCSrcE = 1'b0; FlushD = 1'b0;
    chk("redir_hold1", imem_addr, 32'd8);
    nxt();
    chk("redir_hold2", imem_addr, 32'd8);
    imem_ready = 1'b1;
    nxt();
    chk("redir_discard", 32'(ValidD), 32'd0);
    chk("redir_addr", imem_addr, 32'h100);
    nxt();
    chk("redir_pcd", PCD, 32'h100);

    // stall both stages with PC 4 in Decode, then flush
    doReset();
    nxt(); nxt(); nxt();
    chk("stall_pre_pcd", PCD, 32'd4);
    StallF = 1'b1; StallD = 1'b1;
    repeat (2) begin
      nxt();
      chk("stall_pcd", PCD, 32'd4);
      chk("stall_instr", InstrD, memWord(32'd4));
    end
    StallD = 1'b0; FlushD = 1'b1;
    nxt();
    chk("flush_instr", InstrD, NOP_INSTR);
    chk("flush_valid", 32'(ValidD), 32'd0);
    StallF = 1'b0; FlushD = 1'b0;
    nxt();
    chk("flush_next_pcd", PCD, 32'd8);

    // reset asserted mid-WAIT
    imem_ready = 1'b0;
    nxt(); nxt();
    chk("midrst_busy", 32'(FetchBusyF), 32'd1);
    rst_n = 1'b0;
    #1;
    chk("midrst_req", 32'(imem_req), 32'd0);
    chk("midrst_valid", 32'(ValidD), 32'd0);
    chk("midrst_instr", InstrD, NOP_INSTR);
    chk("midrst_addr", imem_addr, RPC);
    nxt();
    rst_n = 1'b1;
    imem_ready = 1'b1;
    sbLoad(RPC, 1'b0);
    nxt();
    chk("midrst_restart", imem_addr, RPC);

    // misaligned redirect target
    nxt(); nxt();
    redirect(32'h102);
    nxt();
    PCSrcE = 1'b0; FlushD = 1'b0;
    chk("mis_addr", imem_addr, 32'h100);
    nxt();
    chk("mis_pcd", PCD, 32'h100);
`ifdef FETCH_MISALIGN_TRAP_EN
    chk("mis_flag", 32'(MisalignD), 32'd1);
    chk("mis_nop", InstrD, NOP_INSTR);
`else
    chk("mis_word", InstrD, memWord(32'h100));
`endif

    // PC+4 wrap at the top of the address space
    redirect(32'hFFFF_FFF8);
    nxt();
    PCSrcE = 1'b0; FlushD = 1'b0;
    nxt(); nxt();
    chk("wrap_pcd", PCD, 32'hFFFF_FFFC);
    chk("wrap_pcp4", PCPlus4D, 32'd0);
    chk("wrap_addr", imem_addr, 32'd0);

    // randomized traffic
    since = 0;
    for (int c = 0; c < 1500; c++) begin
      imem_ready = ($urandom_range(0, 9) < 7);
      StallF = ($urandom_range(0, 9) == 0);
      StallD = StallF;
      if ($urandom_range(0, 19) == 0 || since > 150) begin
        if ($urandom_range(0, 7) == 0) t = 32'hFFFF_FFF0;
        else t = {20'h0, 10'($urandom_range(0, 1023)), 2'b00};
        redirect(t);
        since = 0;
      end else begin
        PCSrcE = 1'b0;
        FlushD = 1'b0;
        since++;
      end
      nxt();
    end
    PCSrcE = 1'b0; FlushD = 1'b0; StallF = 1'b0; StallD = 1'b0; imem_ready = 1'b1;
    repeat (4) nxt();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
